index_selector: RTL

Parametrised successor to the two-button image selector used by the display path. It debounces N_BTN-independent left/right buttons and maintains an index over an arbitrary item count NUM_ITEMS, which need not be a power of two. It adds wrap or saturate mode, hold-to-auto-repeat, a synchronous direct-load port, and status strobes. It sits between the board buttons and the image/ROM address logic.

---
 rtl/index_selector_pkg.sv | 19 +
 rtl/index_selector_btn_debounce_repeat.sv | 101 ++++++++++
 rtl/index_selector.sv | 84 ++++++++
 3 files changed

// File: rtl/index_selector_pkg.sv
// rtl/index_selector_pkg.sv - shared types and sizing helper for the index selector
package index_selector_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rpt_state_t;

  // Width of a counter that must hold every debounce/repeat terminal count.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/index_selector_btn_debounce_repeat.sv
// rtl/index_selector_btn_debounce_repeat.sv - button synchroniser, debouncer and auto-repeat strobe
module btn_debounce_repeat
  import index_selector_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_RATE     = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic db_level,
  output logic step_strobe
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);

  logic             r_sync0, r_sync1, r_db, r_db_d, r_strobe;
  logic [CNT_W-1:0] r_dcnt, r_rcnt, w_rcnt_next;
  rpt_state_t       r_state, w_state_next;
  logic             w_rise, w_strobe_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync0  <= 1'b0;
      r_sync1  <= 1'b0;
      r_db     <= 1'b0;
      r_db_d   <= 1'b0;
      r_dcnt   <= '0;
      r_rcnt   <= '0;
      r_state  <= IDLE;
      r_strobe <= 1'b0;
    end else begin
      r_sync0 <= btn_raw;
      r_sync1 <= r_sync0;
      r_db_d  <= r_db;
      if (r_sync1 == r_db) begin
        r_dcnt <= '0;
      end else if (r_dcnt == DB_LAST) begin
        r_db   <= ~r_db;
        r_dcnt <= '0;
      end else begin
        r_dcnt <= r_dcnt + CNT_W'(1);
      end
      r_state  <= w_state_next;
      r_rcnt   <= w_rcnt_next;
      r_strobe <= w_strobe_next;
    end
  end

  assign w_rise = r_db & ~r_db_d;

  // Strobes are registered, so the index moves one edge after the FSM decides.
  always_comb begin
    w_state_next  = r_state;
    w_rcnt_next   = r_rcnt;
    w_strobe_next = 1'b0;
    if (!r_db) begin
      w_state_next = IDLE;
      w_rcnt_next  = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_rcnt_next = '0;
          if (w_rise) begin
            w_strobe_next = 1'b1;
            if (REPEAT_DELAY > 0) w_state_next = DELAY;
          end
        end
        DELAY: begin
          if (r_rcnt == RD_LAST) begin
            w_strobe_next = 1'b1;
            w_state_next  = REPEAT;
            w_rcnt_next   = '0;
          end else begin
            w_rcnt_next = r_rcnt + CNT_W'(1);
          end
        end
        REPEAT: begin
          if (r_rcnt == RR_LAST) begin
            w_strobe_next = 1'b1;
            w_rcnt_next   = '0;
          end else begin
            w_rcnt_next = r_rcnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_next = IDLE;
          w_rcnt_next  = '0;
        end
      endcase
    end
  end

  assign db_level    = r_db;
  assign step_strobe = r_strobe;

endmodule

// File: rtl/index_selector.sv
// rtl/index_selector.sv - debounced left/right index selector with wrap/saturate, repeat and load
module index_selector
  import index_selector_pkg::*;
#(
  parameter int NUM_ITEMS       = 4,
  parameter int IDX_W           = $clog2(NUM_ITEMS),
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int WRAP            = 1,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_RATE     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             left_button,
  input  logic             right_button,
  input  logic             load_valid,
  input  logic [IDX_W-1:0] load_index,
  output logic [IDX_W-1:0] index,
  output logic             changed,
  output logic             at_min,
  output logic             at_max
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_ITEMS - 1);

  logic [IDX_W-1:0] r_index, w_next;
  logic             r_changed;
  logic             w_up, w_dn;
  logic [1:0]       w_unused_db;

  btn_debounce_repeat #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_RATE    (REPEAT_RATE)
  ) u_left (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (left_button),
    .db_level   (w_unused_db[0]),
    .step_strobe(w_dn)
  );

  btn_debounce_repeat #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_RATE    (REPEAT_RATE)
  ) u_right (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (right_button),
    .db_level   (w_unused_db[1]),
    .step_strobe(w_up)
  );

  // Ends are compared against LAST explicitly so non-power-of-two counts wrap correctly.
  always_comb begin
    w_next = r_index;
    if (load_valid) begin
      if (load_index <= LAST) w_next = load_index;
    end else if (w_up && !w_dn) begin
      if (r_index == LAST) w_next = (WRAP != 0) ? '0 : r_index;
      else                 w_next = r_index + IDX_W'(1);
    end else if (w_dn && !w_up) begin
      if (r_index == '0) w_next = (WRAP != 0) ? LAST : r_index;
      else               w_next = r_index - IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_index   <= '0;
      r_changed <= 1'b0;
    end else begin
      r_index   <= w_next;
      r_changed <= (w_next != r_index);
    end
  end

  assign index   = r_index;
  assign changed = r_changed;
  assign at_min  = (r_index == '0);
  assign at_max  = (r_index == LAST);

endmodule
